// File: rtl/cva6_lsu_pkg.sv
// Shared defaults and op encoding for the LSU memory-queue model.
package cva6_lsu_pkg;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_LD_DEPTH = 2;
  localparam int unsigned DEF_ST_DEPTH = 2;

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_op_e;
endpackage

// File: rtl/cva6_lsu_fifo.sv
// Circular FIFO with per-slot valid bits; the entry array is exported so a
// neighbour can search every outstanding entry, not just the head.
module cva6_lsu_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 din,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]       cnt,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0][WIDTH-1:0]      entries,
  output logic [DEPTH-1:0]                 vld
);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign entries = mem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      // pop clears before push sets, so a push into the slot just freed wins
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= nxt(rd_ptr);
      end
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= nxt(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cva6_lsu_mq_model.sv
// Split load/store memory queues; loads wait behind any older store to the
// same address, stores drain strictly in order.
module cva6_lsu_mq_model
  import cva6_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned LD_DEPTH = DEF_LD_DEPTH,
  parameter int unsigned ST_DEPTH = DEF_ST_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [ADDR_W-1:0]             instr_i,
  input  logic                          is_load_i,
  input  logic                          instr_valid_i,
  input  logic                          load_mem_resp_i,
  input  logic                          store_mem_resp_i,
  output logic                          ready_o,
  output logic                          load_req_valid_o,
  output logic                          store_req_valid_o,
  output logic [ADDR_W-1:0]             load_addr_o,
  output logic [ADDR_W-1:0]             store_addr_o,
  output logic [$clog2(LD_DEPTH+1)-1:0] load_cnt_o,
  output logic [$clog2(ST_DEPTH+1)-1:0] store_cnt_o,
  output logic                          proto_err_o
);
  lsu_op_e                        op;
  logic                           accept, ld_push, st_push, ld_pop, st_pop;
  logic                           ld_full, ld_empty, st_full, st_empty, hazard;
  logic [LD_DEPTH-1:0][ADDR_W-1:0] ld_entries;
  logic [LD_DEPTH-1:0]            ld_vld;
  logic [ST_DEPTH-1:0][ADDR_W-1:0] st_entries;
  logic [ST_DEPTH-1:0]            st_vld, st_hit;
  logic                           unused_ok;

  assign op      = is_load_i ? LSU_LOAD : LSU_STORE;
  assign ready_o = !ld_full && !st_full;
  assign accept  = instr_valid_i && ready_o;
  assign ld_push = accept && (op == LSU_LOAD);
  assign st_push = accept && (op == LSU_STORE);
  assign ld_pop  = load_mem_resp_i && load_req_valid_o;
  assign st_pop  = store_mem_resp_i && store_req_valid_o;

  cva6_lsu_fifo #(.WIDTH(ADDR_W), .DEPTH(LD_DEPTH)) u_ld_fifo (
    .clk(clk_i), .rst_n(rst_ni), .push(ld_push), .din(instr_i), .pop(ld_pop),
    .dout(load_addr_o), .cnt(load_cnt_o), .full(ld_full), .empty(ld_empty),
    .entries(ld_entries), .vld(ld_vld)
  );

  cva6_lsu_fifo #(.WIDTH(ADDR_W), .DEPTH(ST_DEPTH)) u_st_fifo (
    .clk(clk_i), .rst_n(rst_ni), .push(st_push), .din(instr_i), .pop(st_pop),
    .dout(store_addr_o), .cnt(store_cnt_o), .full(st_full), .empty(st_empty),
    .entries(st_entries), .vld(st_vld)
  );

  // RAW check against every outstanding store, not only the store head
  for (genvar i = 0; i < ST_DEPTH; i++) begin : g_hit
    assign st_hit[i] = st_vld[i] && (st_entries[i] == load_addr_o);
  end
  assign hazard = |st_hit;

  assign store_req_valid_o = !st_empty;
  assign load_req_valid_o  = !ld_empty && !hazard;

  assign unused_ok = ^{ld_entries, ld_vld};

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      proto_err_o <= 1'b0;
    else if ((load_mem_resp_i && !load_req_valid_o) ||
             (store_mem_resp_i && !store_req_valid_o))
      proto_err_o <= 1'b1;
  end
endmodule

// File: doc/cva6_lsu_mq_model.md
CVA6_LSU_MQ_MODEL -- requirements
Module: cva6_lsu_mq_model

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of instruction/address field.
REQ-002 SHALL have parameter LD_DEPTH, default 2, outstanding load capacity; legal range 1..8.
REQ-003 SHALL have parameter ST_DEPTH, default 2, outstanding store capacity; legal range 1..8.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port instr_i  input  ADDR_W  memory address of offered instruction.
REQ-007 SHALL have port is_load_i  input  1  1 = load, 0 = store.
REQ-008 SHALL have port instr_valid_i  input  1  instruction offered this cycle.
REQ-009 SHALL have port load_mem_resp_i  input  1  memory completes the head issued load.
REQ-010 SHALL have port store_mem_resp_i  input  1  memory completes the head issued store.
REQ-011 SHALL have port ready_o  output  1  instruction accepted if instr_valid_i high.
REQ-012 SHALL have ports load_req_valid_o / store_req_valid_o  output  1  head entry issued to memory.
REQ-013 SHALL have ports load_addr_o / store_addr_o  output  ADDR_W  head entry address; 0 when queue empty.
REQ-014 SHALL have ports load_cnt_o / store_cnt_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have port proto_err_o  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL compute ready_o combinationally = (load_cnt_o < LD_DEPTH) && (store_cnt_o < ST_DEPTH), independent of is_load_i.
REQ-017 SHALL enqueue {instr_i} into load FIFO (is_load_i=1) or store FIFO (is_load_i=0) on the edge where instr_valid_i && ready_o; entry is visible at outputs next cycle (1-cycle latency).
REQ-018 SHALL drop instr_valid_i when ready_o=0 with no state change and no error.
REQ-019 SHALL drive store_req_valid_o = (store_cnt_o != 0); stores issue strictly in order.
REQ-020 SHALL drive load_req_valid_o = (load_cnt_o != 0) && !hazard, hazard = load head address equals address of any valid store entry (RAW ordering).
REQ-021 SHALL pop the store head when store_mem_resp_i && store_req_valid_o; pop the load head when load_mem_resp_i && load_req_valid_o.
REQ-022 SHALL, on simultaneous enqueue and pop of the same FIFO, keep count unchanged and wrap pointers modulo depth.
REQ-023 SHALL, on a response with the matching *_req_valid_o low (empty queue or blocked load), ignore it and set proto_err_o.
REQ-024 SHALL re-evaluate hazard every cycle; a blocked load issues the cycle after the last matching store pops.
REQ-025 SHALL permit load and store pops and one enqueue in the same cycle.

Reset
REQ-026 SHALL, while rst_ni=0 at a clock edge, clear both FIFOs, pointers, counts and proto_err_o; all outputs then 0 except ready_o=1.
REQ-027 SHALL treat reset mid-operation as abort: outstanding entries discarded, later responses flag proto_err_o.

Structure
REQ-028 SHALL place ADDR_W/depth defaults and lsu_op_e (LSU_LOAD, LSU_STORE) in package cva6_lsu_pkg.
REQ-029 SHALL instantiate sub-module cva6_lsu_fifo (parametrised width/depth, push/pop/count/full/empty, entry-array visibility for hazard check) twice.

Verification
REQ-030 Store 0xCAD, then store_mem_resp_i 3 cycles later -> store_req_valid_o=1 from cycle+1, store_addr_o=0xCAD, store_cnt_o 1->0 after resp.
REQ-031 Store 0xCAD then load 0xCAD -> load_req_valid_o stays 0 until store resp; rises next cycle with load_addr_o=0xCAD.
REQ-032 Store 0x100 then load 0xCAD -> load issues immediately next cycle (no hazard).
REQ-033 Defaults: two loads 0xA0, 0xA4 -> ready_o=0; third load dropped; one load_mem_resp_i -> ready_o=1, load_addr_o=0xA4.
REQ-034 load_mem_resp_i with empty queue -> proto_err_o=1 and stays 1 until rst_ni=0.
REQ-035 Push load while popping load at count=LD_DEPTH-1 -> count unchanged; run 30 random ops, counts never exceed depth.
